inv_mix_column_seq: RTL and testbench

INV_MIX_COLUMN_SEQ -- requirements
Module: inv_mix_column_seq

---
 rtl/inv_mix_column_seq.sv | 129 ++++++++++++
 tb/tb_inv_mix_column_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_column_seq.sv
// Sequential AES InvMixColumns: one column per cycle through a shared engine, plus inverse-xtime of the round constant.
// Latency 4 cycles from accept to out_valid; in_ready only in IDLE, result held in DONE until out_ready.
// Backpressure: out_ready=0 in DONE stalls indefinitely with outputs stable; new blocks wait on in_ready.
module inv_mix_column_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [7:0]   rcon_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [7:0]   rcon_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm;
    logic [1:0]   col;
    logic [127:0] data_q;
    logic [7:0]   rcon_q;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse of xtime: undo the conditional reduction, then shift back in the lost MSB.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        inv_xtime = b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
    endfunction

    // Product with one of 09/0b/0d/0e from the x2/x4/x8 chain; sel: 0=0e 1=0b 2=0d 3=09.
    function automatic logic [7:0] mul_inv(input logic [7:0] b, input logic [1:0] sel);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (sel)
            2'd0:    mul_inv = x8 ^ x4 ^ x2;
            2'd1:    mul_inv = x8 ^ x2 ^ b;
            2'd2:    mul_inv = x8 ^ x4 ^ b;
            default: mul_inv = x8 ^ b;
        endcase
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        inv_mix_col[31:24] = mul_inv(a0, 2'd0) ^ mul_inv(a1, 2'd1) ^ mul_inv(a2, 2'd2) ^ mul_inv(a3, 2'd3);
        inv_mix_col[23:16] = mul_inv(a0, 2'd3) ^ mul_inv(a1, 2'd0) ^ mul_inv(a2, 2'd1) ^ mul_inv(a3, 2'd2);
        inv_mix_col[15:8]  = mul_inv(a0, 2'd2) ^ mul_inv(a1, 2'd3) ^ mul_inv(a2, 2'd0) ^ mul_inv(a3, 2'd1);
        inv_mix_col[7:0]   = mul_inv(a0, 2'd1) ^ mul_inv(a1, 2'd2) ^ mul_inv(a2, 2'd3) ^ mul_inv(a3, 2'd0);
    endfunction

    // Single shared engine fed by the column counter.
    always_comb begin
        col_in = 32'h0;
        case (col)
            2'd0:    col_in = data_q[127:96];
            2'd1:    col_in = data_q[95:64];
            2'd2:    col_in = data_q[63:32];
            default: col_in = data_q[31:0];
        endcase
    end

    assign col_out = inv_mix_col(col_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            col       <= 2'd0;
            data_q    <= 128'h0;
            rcon_q    <= 8'h00;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= state_in;
                        rcon_q   <= inv_xtime(rcon_in);
                        col      <= 2'd0;
                        fsm      <= CALC;
                        in_ready <= 1'b0;
                    end
                end
                CALC: begin
                    case (col)
                        2'd0:    data_q[127:96] <= col_out;
                        2'd1:    data_q[95:64]  <= col_out;
                        2'd2:    data_q[63:32]  <= col_out;
                        default: data_q[31:0]   <= col_out;
                    endcase
                    col <= col + 2'd1;
                    if (col == 2'd3) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign state_out = data_q;
    assign rcon_out  = rcon_q;

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// Bench for inv_mix_column_seq: constant vector table, corner-case sequences and random blocks vs. a GF(2^8) model.
module tb_inv_mix_column_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [7:0]   rcon_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [7:0]   rcon_out;

    int checks = 0;
    int errors = 0;

    inv_mix_column_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .rcon_in   (rcon_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .rcon_out  (rcon_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] st;
        logic [7:0]   rc;
        logic [127:0] exp_st;
        logic [7:0]   exp_rc;
    } vec_t;

    vec_t vecs[8];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        p  = 8'h00;
        aa = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11b;
        end
        return p;
    endfunction

    // Column mix with a circulant matrix whose first row is {k0,k1,k2,k3}.
    function automatic logic [127:0] mix_model(input logic [127:0] s, input logic [31:0] k);
        logic [7:0] b[16];
        logic [7:0] kk[4];
        logic [7:0] o;
        logic [127:0] r;
        for (int i = 0; i < 4; i++) kk[i] = k[31-8*i -: 8];
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        r = 128'h0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                o = 8'h00;
                for (int j = 0; j < 4; j++) o = o ^ gf_mul(b[4*c+j], kk[(j - row + 4) % 4]);
                r[127-8*(4*c+row) -: 8] = o;
            end
        return r;
    endfunction

    function automatic logic [127:0] inv_model(input logic [127:0] s);
        return mix_model(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fwd_model(input logic [127:0] s);
        return mix_model(s, 32'h02030101);
    endfunction

    // Previous round constant: the unique x with 2*x == rc in GF(2^8).
    function automatic logic [7:0] rcon_model(input logic [7:0] rc);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 256; i++)
            if (gf_mul(i[7:0], 8'h02) == rc) x = i[7:0];
        return x;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    // Present a block, wait for acceptance, measure latency, hold the result for 'stall' cycles, then hand it off.
    task automatic run_block(input logic [127:0] st, input logic [7:0] rc, input int stall,
                             output int lat, output logic [127:0] so, output logic [7:0] ro);
        int w;
        state_in = st;
        rcon_in  = rc;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready stayed 0 for %0d cycles", w);
        end
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        so = state_out;
        ro = rcon_out;
        repeat (stall) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    int           lat;
    logic [127:0] so, st_a, st_b;
    logic [7:0]   ro;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = 128'h0;
        rcon_in   = 8'h00;

        // Known vector, rcon sweep (all-01 columns are fixed points), and an all-zero block.
        vecs[0] = '{128'h8e4da1bc_9fdc589d_4d7ebdf8_01010101, 8'h1b,
                    128'hdb135345_f20a225c_2d26314c_01010101, 8'h80};
        vecs[1] = '{{4{32'h01010101}}, 8'h01, {4{32'h01010101}}, 8'h8d};
        vecs[2] = '{{4{32'h01010101}}, 8'h02, {4{32'h01010101}}, 8'h01};
        vecs[3] = '{{4{32'h01010101}}, 8'h80, {4{32'h01010101}}, 8'h40};
        vecs[4] = '{{4{32'h01010101}}, 8'h36, {4{32'h01010101}}, 8'h1b};
        vecs[5] = '{{4{32'h01010101}}, 8'h1b, {4{32'h01010101}}, 8'h80};
        // 8d is odd: (8d^1b)>>1 | 80 = cb, and 2*cb = 8d.
        vecs[6] = '{{4{32'h01010101}}, 8'h8d, {4{32'h01010101}}, 8'hcb};
        vecs[7] = '{128'h0, 8'h00, 128'h0, 8'h00};

        #3;
        chk("reset_out_valid", {127'h0, out_valid}, 128'h0);
        chk("reset_in_ready", {127'h0, in_ready}, 128'h1);
        chk("reset_state_out", state_out, 128'h0);
        chk("reset_rcon_out", {120'h0, rcon_out}, 128'h0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_block(vecs[i].st, vecs[i].rc, 0, lat, so, ro);
            chk($sformatf("vec%0d_state", i), so, vecs[i].exp_st);
            chk($sformatf("vec%0d_rcon", i), {120'h0, ro}, {120'h0, vecs[i].exp_rc});
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
        end

        // Round trip: the result must forward-mix back to 00..0f.
        st_a = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        run_block(st_a, 8'h36, 0, lat, so, ro);
        chk("roundtrip_fwd", fwd_model(so), st_a);
        chk("roundtrip_model", so, inv_model(st_a));

        // Backpressure: second block pending while the first is held in DONE.
        st_a = {$urandom, $urandom, $urandom, $urandom};
        st_b = {$urandom, $urandom, $urandom, $urandom};
        state_in = st_a;
        rcon_in  = 8'h04;
        in_valid = 1'b1;
        step();
        state_in = st_b;
        rcon_in  = 8'h08;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("bp_first_latency", 128'(lat), 128'd4);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold%0d", i),
                {out_valid, in_ready, rcon_out, state_out},
                {1'b1, 1'b0, 8'h02, inv_model(st_a)});
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_after_handshake", {126'h0, out_valid, in_ready}, 128'h1);
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("bp_second_latency", 128'(lat), 128'd4);
        chk("bp_second_state", state_out, inv_model(st_b));
        chk("bp_second_rcon", {120'h0, rcon_out}, 128'h04);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Mid-op reset in the second CALC cycle.
        state_in = {$urandom, $urandom, $urandom, $urandom};
        rcon_in  = 8'h10;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {out_valid, in_ready, rcon_out, state_out}, {1'b0, 1'b1, 8'h00, 128'h0});
        #2;
        rst = 1'b0;
        st_a = {$urandom, $urandom, $urandom, $urandom};
        run_block(st_a, 8'h20, 0, lat, so, ro);
        chk("midrst_next_state", so, inv_model(st_a));
        chk("midrst_next_latency", 128'(lat), 128'd4);

        // Back-to-back: in_valid and out_ready both held high.
        begin
            logic [127:0] blk[5];
            logic [127:0] expq[$];
            int nin, nout, cyc, last;
            for (int i = 0; i < 5; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
            nin = 0;
            nout = 0;
            last = -1;
            state_in  = blk[0];
            rcon_in   = 8'h01;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            for (cyc = 0; cyc < 80 && nout < 5; cyc++) begin
                if (out_valid) begin
                    chk($sformatf("b2b_data%0d", nout), state_out, expq.pop_front());
                    if (last >= 0) chk($sformatf("b2b_period%0d", nout), 128'(cyc - last), 128'd6);
                    last = cyc;
                    nout++;
                end
                if (in_ready && nin < 5) begin
                    expq.push_back(inv_model(blk[nin]));
                    nin++;
                    step();
                    if (nin < 5) state_in = blk[nin];
                    else in_valid = 1'b0;
                end else begin
                    step();
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk("b2b_count", 128'(nout), 128'd5);
            step();
        end

        // Random blocks with random output stalls.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] rc;
            st_a = {$urandom, $urandom, $urandom, $urandom};
            rc   = 8'($urandom_range(0, 255));
            run_block(st_a, rc, int'($urandom_range(0, 3)), lat, so, ro);
            chk($sformatf("rand%0d_state", i), so, inv_model(st_a));
            chk($sformatf("rand%0d_rcon", i), {120'h0, ro}, {120'h0, rcon_model(rc)});
            chk($sformatf("rand%0d_latency", i), 128'(lat), 128'd4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
